// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN to build the two's-complement variant (quotient truncates toward zero).
module div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div0_o,
    output logic             valid_o,
    input  logic             ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             divisor_zero;
    logic             last_step;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
`endif

    assign divisor_zero = (divisor_i == '0);
    assign last_step    = (state == CALC) && (count == LAST_STEP);

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (valid_i) state_next = divisor_zero ? DONE : CALC;
            CALC: if (last_step) state_next = DONE;
            DONE: if (ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == IDLE);
        valid_o = (state == DONE);
    end

    // The dividend register doubles as the quotient shift register: dividend
    // bits leave at the top while quotient bits enter at the bottom.
    always_comb begin
        shifted  = {part_rem, dvd_q[WIDTH-1]};
        ge       = (shifted >= {1'b0, dvs_q});
        rem_next = ge ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
        quo_next = {dvd_q[WIDTH-2:0], ge};
    end

`ifdef DIV_SIGNED_EN
    always_comb begin
        dvd_mag = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
        dvs_mag = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
        res_q   = neg_q ? -quo_next : quo_next;
        res_r   = neg_r ? -rem_next : rem_next;
    end
`else
    always_comb begin
        dvd_mag = dividend_i;
        dvs_mag = divisor_i;
        res_q   = quo_next;
        res_r   = rem_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            count       <= '0;
            part_rem    <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div0_o      <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        dvd_q    <= dvd_mag;
                        dvs_q    <= dvs_mag;
                        part_rem <= '0;
                        count    <= '0;
`ifdef DIV_SIGNED_EN
                        neg_q    <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
                        neg_r    <= dividend_i[WIDTH-1];
`endif
                        if (divisor_zero) begin
                            quotient_o  <= '1;
                            remainder_o <= dividend_i;
                            div0_o      <= 1'b1;
                        end else begin
                            div0_o <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    part_rem <= rem_next;
                    dvd_q    <= quo_next;
                    count    <= count + 1'b1;
                    if (last_step) begin
                        quotient_o  <= res_q;
                        remainder_o <= res_r;
                        div0_o      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (WIDTH=8); signed vectors run when DIV_SIGNED_EN is defined.
module tb_div_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_ni;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div0_o;
    logic             valid_o;
    logic             ready_i;

    int checks = 0;
    int errors = 0;

    div_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o),
        .div0_o     (div0_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges after the accept edge until valid_o rises.
    task automatic waitValid(output int lat);
        lat = 0;
        while (!valid_o && lat < 40) begin
            stepCycle();
            lat++;
        end
        if (!valid_o) checkOutput("valid_timeout", 32'(valid_o), 32'd1);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
        int guard = 0;
        while (!ready_o && guard < 40) begin
            stepCycle();
            guard++;
        end
        if (!ready_o) checkOutput("ready_timeout", 32'(ready_o), 32'd1);
        dividend_i = dvd;
        divisor_i  = dvs;
        valid_i    = 1'b1;
        stepCycle();
        valid_i    = 1'b0;
    endtask

    task automatic runDivision(input string tag, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                               input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                               input logic exp_d0, input int exp_lat);
        int lat;
        ready_i = 1'b1;
        applyStimulus(dvd, dvs);
        waitValid(lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_ready_busy"}, 32'(ready_o), 32'd0);
        checkOutput({tag, "_quotient"}, 32'(quotient_o), 32'(exp_q));
        checkOutput({tag, "_remainder"}, 32'(remainder_o), 32'(exp_r));
        checkOutput({tag, "_div0"}, 32'(div0_o), 32'(exp_d0));
        stepCycle();
        checkOutput({tag, "_handoff_valid"}, 32'(valid_o), 32'd0);
        checkOutput({tag, "_handoff_ready"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        int lat;
        rst_ni     = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        valid_i    = 1'b0;
        ready_i    = 1'b0;
        stepCycle();
        stepCycle();
        rst_ni = 1'b1;
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_quotient", 32'(quotient_o), 32'd0);
        checkOutput("rst_remainder", 32'(remainder_o), 32'd0);
        checkOutput("rst_div0", 32'(div0_o), 32'd0);

        runDivision("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, WIDTH);
        runDivision("dz", 8'hA5, 8'h00, 8'hFF, 8'hA5, 1'b1, 0);
        runDivision("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, WIDTH);
        runDivision("d4_9", 8'd4, 8'd9, 8'd0, 8'd4, 1'b0, WIDTH);

        // Consumer stall: result must hold while ready_i is low.
        ready_i = 1'b0;
        applyStimulus(8'd255, 8'd1);
        waitValid(lat);
        for (int i = 0; i < 5; i++) begin
`ifdef DIV_SIGNED_EN
            checkOutput("stall_quotient", 32'(quotient_o), 32'hFF);
`else
            checkOutput("stall_quotient", 32'(quotient_o), 32'd255);
`endif
            checkOutput("stall_remainder", 32'(remainder_o), 32'd0);
            checkOutput("stall_valid", 32'(valid_o), 32'd1);
            stepCycle();
        end
        ready_i = 1'b1;
        checkOutput("stall_still_valid", 32'(valid_o), 32'd1);
        stepCycle();
        checkOutput("stall_release_ready", 32'(ready_o), 32'd1);

        // Back-to-back with valid_i held high and operands disturbed mid-calc.
        dividend_i = 8'd9;
        divisor_i  = 8'd3;
        valid_i    = 1'b1;
        stepCycle();
        dividend_i = 8'd77;
        divisor_i  = 8'd5;
        stepCycle();
        dividend_i = 8'd50;
        divisor_i  = 8'd0;
        waitValid(lat);
        checkOutput("b2b1_latency", 32'(lat + 1), 32'(WIDTH));
        checkOutput("b2b1_quotient", 32'(quotient_o), 32'd3);
        checkOutput("b2b1_remainder", 32'(remainder_o), 32'd0);
        dividend_i = 8'd3;
        divisor_i  = 8'd9;
        stepCycle();
        checkOutput("b2b_no_same_edge_accept", 32'(ready_o), 32'd1);
        stepCycle();
        valid_i    = 1'b0;
        dividend_i = 8'd200;
        divisor_i  = 8'd1;
        waitValid(lat);
        checkOutput("b2b2_latency", 32'(lat), 32'(WIDTH));
        checkOutput("b2b2_quotient", 32'(quotient_o), 32'd0);
        checkOutput("b2b2_remainder", 32'(remainder_o), 32'd3);
        stepCycle();

        // Reset during the fourth CALC cycle aborts the operation.
        applyStimulus(8'd200, 8'd13);
        stepCycle();
        stepCycle();
        stepCycle();
        rst_ni = 1'b0;
        stepCycle();
        rst_ni = 1'b1;
        checkOutput("abort_valid", 32'(valid_o), 32'd0);
        checkOutput("abort_ready", 32'(ready_o), 32'd1);
        checkOutput("abort_quotient", 32'(quotient_o), 32'd0);
        checkOutput("abort_remainder", 32'(remainder_o), 32'd0);
`ifdef DIV_SIGNED_EN
        runDivision("d200_13", 8'd200, 8'd13, 8'hFC, 8'hFC, 1'b0, WIDTH);
        runDivision("sm7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, WIDTH);
        runDivision("sm128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, WIDTH);
        runDivision("s7_m2", 8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, WIDTH);
        runDivision("sdz", 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1, 0);
`else
        runDivision("d200_13", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, WIDTH);
        runDivision("d255_16", 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, WIDTH);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle unsigned integer divider: quotient and remainder for an arbitrary divisor, one quotient bit per clock (restoring algorithm).
- Successor to the fixed shift-based divide-by-4 stage. Handles any divisor, carries a valid/ready handshake on input and output, and reports divide-by-zero.
- Sits between a producer and a consumer in the datapath. Both sides may stall.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder (legal range 2..32)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_ni  input  1  synchronous active-low reset, sampled on rising edge of clk
- dividend_i  input  WIDTH  dividend
- divisor_i  input  WIDTH  divisor
- valid_i  input  1  request present
- ready_o  output  1  block can accept a request
- quotient_o  output  WIDTH  quotient
- remainder_o  output  WIDTH  remainder
- div0_o  output  1  result came from a zero divisor; qualified by valid_o
- valid_o  output  1  result present
- ready_i  input  1  consumer accepts result

Behaviour:
- Interface: one clock clk. Reset rst_ni is synchronous, active-low.
- Reset (rst_ni=0 at an edge):
  - state=IDLE.
  - ready_o=1 in the following cycle.
  - valid_o=0, div0_o=0, quotient_o=0, remainder_o=0.
  - Internal counter, partial remainder and operand registers cleared.
- States:
  - IDLE: ready_o=1, valid_o=0.
  - CALC: ready_o=0, valid_o=0.
  - DONE: ready_o=0, valid_o=1.
- Accept: on an edge with state=IDLE and valid_i=1, capture dividend_i and divisor_i.
  - divisor_i==0 -> DONE, with quotient_o = all ones, remainder_o = dividend_i, div0_o=1.
  - Otherwise -> CALC, counter=0, partial remainder=0, div0_o=0.
- CALC step (one per edge):
  - Shift the next dividend bit (MSB first) into the partial remainder, WIDTH+1 bits wide.
  - Trial subtract the divisor. If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - After exactly WIDTH CALC edges -> DONE.
  - valid_o is first high in the cycle after acceptance edge + WIDTH edges. Nonzero-divisor latency = WIDTH cycles from accept to valid_o.
  - Zero-divisor latency = 1 cycle.
- DONE:
  - quotient_o, remainder_o and div0_o are held stable while valid_o=1 and ready_i=0.
  - Edge with ready_i=1 -> IDLE.
  - A new request cannot be accepted on the same edge as result hand-off. Minimum issue interval is WIDTH+2 cycles.
- quotient_o, remainder_o and div0_o keep their last values in IDLE and CALC. They are updated only on entry to DONE.
- Input stability: dividend_i, divisor_i and valid_i are ignored outside IDLE. Operands are registered at accept, so later changes have no effect.
- Arithmetic invariant for a nonzero divisor: dividend = quotient*divisor + remainder, with remainder < divisor.
- Boundaries:
  - dividend < divisor -> quotient 0, remainder = dividend.
  - divisor=1 -> quotient = dividend, remainder 0.
  - dividend=0 -> quotient 0, remainder 0.
- Reset mid-operation (CALC or DONE): abort; behave exactly as reset above. No partial result is ever presented.
- ready_i is ignored while valid_o=0.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: operands and results are two's complement.
  - Operands are converted to magnitudes at accept. The unsigned core runs unchanged. Signs are applied on entry to DONE.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Divisor 0 -> quotient = -1 (all ones), remainder = dividend, div0_o=1.
  - Overflow case, most-negative / -1 -> quotient = most-negative, remainder 0, div0_o=0.
  - Latency is the same as the unsigned build.
- Undefined: pure unsigned behaviour as specified above. No sign logic is present.

Test Plan:
- WIDTH=8, reset, then dividend 100, divisor 7, ready_i=1 -> ready_o low for 9 cycles; valid_o high exactly 8 cycles after accept; quotient 14, remainder 2, div0_o=0; ready_o=1 the cycle after hand-off.
- dividend 0xA5, divisor 0 -> valid_o 1 cycle after accept; quotient 0xFF, remainder 0xA5, div0_o=1.
- dividend 255, divisor 1, ready_i held 0 for 5 cycles after valid_o -> outputs stable at quotient 255, remainder 0 for all 5 cycles; state returns to IDLE only on the ready_i=1 edge.
- Back-to-back: 9/3 then 3/9, with valid_i held high and operands changed during CALC -> results 3 r 0, then 0 r 3; mid-CALC operand changes have no effect.
- Accept 200/13, assert rst_ni=0 on the 4th CALC cycle -> next cycle valid_o=0, ready_o=1, quotient 0, remainder 0; a following 200/13 completes correctly as 15 r 5.
- DIV_SIGNED_EN defined, WIDTH=8:
  - -7/2 -> quotient -3 (0xFD), remainder -1 (0xFF).
  - -128/-1 -> quotient 0x80, remainder 0.
  - 7/-2 -> quotient -3, remainder 1.
